// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, computed one 4-bit
// lookahead slice per clock, least significant nibble first, between a
// valid/ready producer and consumer.
// Optional feature macro: NIBBLE_SUB_SKID_EN -- lets DONE retire a result and
// accept new operands on the same edge (DONE -> BUSY), shortening the
// initiation interval from NIB+2 to NIB+1 cycles.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
      $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic             ready_en_reg;   // low during reset, 1 from first clock after release
  logic [WIDTH-1:0] a_reg, b_reg, diff_reg, diff_next;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;
  logic             bout_reg, zero_reg, ovf_reg;
  logic             accept;

  logic [3:0] x_nib, y_nib, g, p, s;
  logic [4:0] c;

  // Select the current operand nibbles; b is inverted so the adder subtracts.
  always_comb begin
    x_nib = '0;
    y_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_reg == IW'(i)) begin
        x_nib = a_reg[4*i +: 4];
        y_nib = ~b_reg[4*i +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice; the carry here is the inverted borrow.
  always_comb begin
    g    = x_nib & y_nib;
    p    = x_nib ^ y_nib;
    c[0] = carry_reg;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
  end

  // Merge the freshly computed nibble into the result at the current index.
  always_comb begin
    diff_next = diff_reg;
    for (int i = 0; i < NIB; i++) begin
      if (idx_reg == IW'(i)) begin
        diff_next[4*i +: 4] = s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = ready_en_reg;
        accept   = in_valid & ready_en_reg;
        if (accept) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (idx_reg == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef NIBBLE_SUB_SKID_EN
        // Retiring the result frees the datapath on the same edge.
        in_ready = out_ready;
        accept   = in_valid & out_ready;
        if (accept) begin
          state_next = BUSY;
        end else if (out_ready) begin
          state_next = IDLE;
        end
`else
        if (out_ready) begin
          state_next = IDLE;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latch, nibble-serial datapath and final flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      diff_reg     <= '0;
      carry_reg    <= 1'b0;
      idx_reg      <= '0;
      bout_reg     <= 1'b0;
      zero_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= ~bin;
        idx_reg   <= '0;
      end else if (state_reg == BUSY) begin
        diff_reg  <= diff_next;
        carry_reg <= c[4];
        idx_reg   <= idx_reg + IW'(1);
        if (idx_reg == LAST) begin
          // Flags are frozen here so they stay stable throughout DONE.
          bout_reg <= ~c[4];
          zero_reg <= (diff_next == '0);
          ovf_reg  <= (a_reg[MSB] != b_reg[MSB]) & (diff_next[MSB] != a_reg[MSB]);
        end
      end
    end
  end

  assign diff = diff_reg;
  assign bout = bout_reg;
  assign zero = zero_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16): directed and
// random operations against an arithmetic reference model.
module tb_nibble_serial_subtractor;

  localparam int W   = 16;
  localparam int NIB = W / 4;
`ifdef NIBBLE_SUB_SKID_EN
  localparam int II = NIB + 1;
`else
  localparam int II = NIB + 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout, zero, ovf;

  int errors = 0;
  int checks = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: {bout, zero, ovf, diff} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    int          r;
    logic [W-1:0] d;
    logic        mbo, mz, mo;
    r   = int'(ma) - int'(mb) - int'(mbin);
    d   = W'(r);
    mbo = (int'(ma) < int'(mb) + int'(mbin));
    mz  = (d == '0);
    mo  = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
    return {mbo, mz, mo, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_result(input string tag, input logic [W+2:0] e);
    check({tag, "_diff"}, 32'(diff), 32'(e[W-1:0]));
    check({tag, "_bout"}, 32'(bout), 32'(e[W+2]));
    check({tag, "_zero"}, 32'(zero), 32'(e[W+1]));
    check({tag, "_ovf"},  32'(ovf),  32'(e[W]));
  endtask

  // One complete operation; caller is positioned 1 time unit after an edge.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tbin, input int hold);
    logic [W+2:0] e;
    int n;
    int lat;
    e = model(ta, tbv, tbin);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tbv; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble the inputs while busy: only the latched copies may matter.
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'(NIB));
    check_result(tag, e);
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check_result({tag, "_hold"}, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_retired"}, 32'(out_valid), 32'd0);
    $display("op %s: a=%h b=%h bin=%0d -> diff=%h bout=%0d zero=%0d ovf=%0d lat=%0d",
             tag, ta, tbv, tbin, e[W-1:0], e[W+2], e[W+1], e[W], lat);
  endtask

  logic [W-1:0] qa [3];
  logic [W-1:0] qb [3];
  logic         qbin [3];
  logic [W+2:0] expq [$];

  initial begin
    logic [W+2:0] e;
    int k, got, cyc, last;
    logic fin, fout;

    // Reset state.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({bout, zero, ovf}), 32'd0);
    rst = 1'b0;
    #1;
    check("release_in_ready_pre_clock", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("release_in_ready_post_clock", 32'(in_ready), 32'd1);

    // Directed operations.
    run_op("basic", 16'h1234, 16'h0034, 1'b0, 0);
    run_op("underflow", 16'h0000, 16'h0001, 1'b0, 0);
    run_op("signed_ovf", 16'h8000, 16'h0001, 1'b0, 0);
    run_op("zero_res", 16'h5555, 16'h5554, 1'b1, 0);
    run_op("ripple", 16'h00FF, 16'h00FF, 1'b1, 0);
    run_op("hold10", 16'hA5C3, 16'h3C5A, 1'b0, 10);

    // Reset two cycles into BUSY aborts the operation.
    a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_flags", 32'({bout, zero, ovf}), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_release_pre_clock", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("abort_release_post_clock", 32'(in_ready), 32'd1);
    for (int i = 0; i < NIB + 2; i++) begin
      check("abort_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_op("after_abort", 16'h8000, 16'h7FFF, 1'b1, 0);

    // Random operations.
    for (int i = 0; i < 20; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Back-to-back throughput with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      qa[i] = W'($urandom); qb[i] = W'($urandom); qbin[i] = 1'($urandom);
    end
    a = qa[0]; b = qb[0]; bin = qbin[0]; in_valid = 1'b1; out_ready = 1'b1;
    k = 0; got = 0; cyc = 0; last = -1;
    while (got < 3 && cyc < 100) begin
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (fout) begin
        e = (expq.size() > 0) ? expq.pop_front() : '1;
        check_result("tput", e);
        if (last >= 0) begin
          check("tput_interval", 32'(cyc - last), 32'(II));
        end
        $display("tput result %0d at cycle %0d: diff=%h", got, cyc, diff);
        last = cyc;
        got++;
      end
      if (fin) begin
        expq.push_back(model(a, b, bin));
      end
      @(posedge clk); #1;
      cyc++;
      if (fin) begin
        k++;
        if (k < 3) begin
          a = qa[k]; b = qb[k]; bin = qbin[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("tput_count", 32'(got), 32'd3);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor: computes diff = a - b - bin, one 4-bit lookahead slice per clock, least significant nibble first.
- Borrow chaining is the inverse use of the team's 4-bit carry-lookahead adder. Each slice adds a to the inverted b with carry-in equal to the inverted borrow.
- Sits between a valid/ready producer and consumer in the datapath. It trades latency for area against a full-width combinational subtractor.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- NIB (derived, not overridable), WIDTH/4, number of slice cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b, bin presented
- in_ready  output  1  block accepts operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 when unsigned a < b + bin
- zero  output  1  diff == 0
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset is asynchronous, active-high. While rst is high:
  - state = IDLE; diff, bout, zero, ovf, out_valid = 0; internal counter and carry = 0.
  - in_ready = 0 while rst is high, then 1 from the first clock after release.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - Accept happens on in_valid & in_ready. On accept: latch a and b, set carry = ~bin, idx = 0, go to BUSY.
- State BUSY:
  - in_ready = 0. Inputs are ignored; only the latched copies are used.
  - Each cycle the slice computes {c4, s[3:0]} = a_nib + ~b_nib + carry using G/P lookahead terms (G = x&y, P = x^y, full 4-level carry equations).
  - Write s into diff[4*idx+3:4*idx], set carry = c4, idx = idx + 1.
  - When idx == NIB-1, go to DONE.
- State DONE:
  - out_valid = 1.
  - Final values: bout = ~carry; zero = (diff == 0); ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
  - diff, bout, zero, ovf are held stable while out_valid & ~out_ready, for any number of cycles.
  - On out_ready, go to IDLE.
- Latency: the accept edge is cycle 0, and out_valid rises after NIB clock edges (4 for WIDTH=16). Minimum initiation interval is NIB+2 cycles.
- Partial diff nibbles may be observed during BUSY; they are only defined while out_valid = 1.
- Asserting rst mid-BUSY or mid-DONE immediately aborts the operation. The result is lost and no out_valid pulse is produced.
- WIDTH=4 case: BUSY lasts exactly one cycle.
- in_valid high while not ready: the operands are not consumed. The producer holds them per valid/ready rules.

Optional Feature:
- Macro: NIBBLE_SUB_SKID_EN
- Defined:
  - In DONE, in_ready = out_ready.
  - If out_ready & in_valid fire in the same cycle, the result retires and the new operands are latched. The state goes directly DONE -> BUSY.
  - Initiation interval becomes NIB+1 cycles.
- Undefined: in_ready is 1 only in IDLE, as specified in Behaviour.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0034, bin=0 -> out_valid 4 edges after accept; diff=0x1200, bout=0, zero=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
- a=0x5555, b=0x5554, bin=1 -> diff=0x0000, zero=1, bout=0. Then a=0x00FF, b=0x00FF, bin=1 -> diff=0xFFFF, bout=1 (borrow ripples through all nibbles).
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout. Change a and b during BUSY -> result unaffected.
- Assert rst two cycles into BUSY -> all outputs 0 immediately (asynchronously); in_ready=1 on the first clock after release; the next operation completes correctly.
- With NIBBLE_SUB_SKID_EN, 3 back-to-back ops with in_valid and out_ready held high -> one result every 5 cycles, all correct. Without the macro -> one result every 6 cycles.
